// File: rtl/uvmt_cv32e40x_pma_split_model.sv
`default_nettype none
// ============================================================================
// Module      : uvmt_cv32e40x_pma_split_model
// Description : Observes a bus handshake and produces a PMA verdict per
//               transaction. Misaligned accesses are tracked across their two
//               beats. Per-region hit counters are maintained.
// Revision    : 1.0 - initial release
// ============================================================================
package uvmt_cv32e40x_pma_split_pkg;
    typedef struct packed {
        logic [31:0] word_addr_low;
        logic [31:0] word_addr_high;
        logic        main;
        logic        bufferable;
    } pma_cfg_t;
endpackage

module uvmt_cv32e40x_pma_split_model
    import uvmt_cv32e40x_pma_split_pkg::*;
#(
    parameter int          PMA_NUM_REGIONS = 0,
    parameter pma_cfg_t    PMA_CFG [(PMA_NUM_REGIONS > 0 ? PMA_NUM_REGIONS - 1 : 0):0] = '{default: '0},
    parameter logic [31:0] DM_REGION_START = 32'h0,
    parameter logic [31:0] DM_REGION_END   = 32'h0,
    parameter bit          IS_INSTR_SIDE   = 1'b0,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trans_valid_i,
    input  logic                      trans_ready_i,
    input  logic [31:0]               trans_addr_i,
    input  logic [1:0]                trans_size_i,
    input  logic                      trans_we_i,
    input  logic                      trans_pushpop_i,
    input  logic                      dbg_i,
    input  logic                      clr_cnt_i,
    output logic                      verdict_valid_o,
    output logic                      verdict_allow_o,
    output logic                      verdict_main_o,
    output logic                      verdict_bufferable_o,
    output logic                      verdict_split_o,
    output logic                      verdict_dm_o,
    output logic [4:0]                verdict_idx_o,
    output logic                      protocol_err_o,
    output logic [16*CNT_WIDTH-1:0]   hit_cnt_o
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_SECOND  = 1'b1;
    localparam logic [4:0]  IDX_NONE   = 5'd16;
    localparam logic        NO_REGIONS = (PMA_NUM_REGIONS == 0);
    localparam logic [31:0] DM_SPAN    = DM_REGION_END - DM_REGION_START;

    logic [33:0] addr34;
    logic        beat_acc, size_bad, beat_mis, beat_dm, beat_hit;
    logic        cfg_main, cfg_buf;
    logic        beat_main, beat_buf, beat_allow;
    logic [4:0]  beat_idx;
    logic [15:0] rgn_match, rgn_main, rgn_buf, rgn_sel;
    logic [16:0] rgn_below;
    logic [4:0]  idx_chain [17];

    logic [0:0]  state_q, state_d;
    logic        first_allow_q, first_allow_d, first_main_q, first_main_d;
    logic        first_buf_q, first_buf_d, first_dm_q, first_dm_d;
    logic [4:0]  first_idx_q, first_idx_d;
    logic [29:0] exp_word_q, exp_word_d;
    logic        verdict_valid_q, verdict_valid_d, verdict_allow_q, verdict_allow_d;
    logic        verdict_main_q, verdict_main_d, verdict_buf_q, verdict_buf_d;
    logic        verdict_split_q, verdict_split_d, verdict_dm_q, verdict_dm_d;
    logic [4:0]  verdict_idx_q, verdict_idx_d;
    logic        perr_q, perr_d;

    assign addr34   = {2'b00, trans_addr_i};
    assign beat_acc = trans_valid_i & trans_ready_i;
    assign size_bad = (trans_size_i == 2'd3);
    // A beat spills into the next word when its last byte lands past offset 3
    assign beat_mis = ({1'b0, trans_addr_i[1:0]} + (3'd1 << trans_size_i)) > 3'd4;
    assign beat_dm  = dbg_i & ((trans_addr_i - DM_REGION_START) <= DM_SPAN);

    // Region decode: the lowest matching index wins through the "below" chain
    assign rgn_below[0] = 1'b0;
    assign idx_chain[0] = 5'd0;
    for (genvar gi = 0; gi < 16; gi++) begin : g_region
        if (gi < PMA_NUM_REGIONS) begin : g_valid
            localparam logic [33:0] LO   = {PMA_CFG[gi].word_addr_low,  2'b00};
            localparam logic [33:0] HI   = {PMA_CFG[gi].word_addr_high, 2'b00};
            localparam logic [33:0] SPAN = (HI > LO) ? (HI - LO) : 34'd0;
            assign rgn_match[gi] = ((addr34 - LO) < SPAN);
            assign rgn_main[gi]  = PMA_CFG[gi].main;
            assign rgn_buf[gi]   = PMA_CFG[gi].bufferable;
        end else begin : g_unused
            assign rgn_match[gi] = 1'b0;
            assign rgn_main[gi]  = 1'b0;
            assign rgn_buf[gi]   = 1'b0;
        end
        assign rgn_sel[gi]       = rgn_match[gi] & ~rgn_below[gi];
        assign rgn_below[gi+1]   = rgn_below[gi] | rgn_match[gi];
        assign idx_chain[gi+1]   = idx_chain[gi] | (rgn_sel[gi] ? 5'(gi) : 5'd0);
    end

    assign beat_hit   = rgn_below[16];
    assign cfg_main   = |(rgn_sel & rgn_main);
    assign cfg_buf    = |(rgn_sel & rgn_buf);
    assign beat_main  = beat_dm | (beat_hit ? cfg_main : NO_REGIONS);
    assign beat_buf   = ~beat_dm & beat_hit & cfg_buf & trans_we_i & ~IS_INSTR_SIDE;
    assign beat_allow = beat_dm | (IS_INSTR_SIDE ? beat_main
                                                 : (beat_main | (~beat_mis & ~trans_pushpop_i)));
    assign beat_idx   = (beat_dm | ~beat_hit) ? IDX_NONE : idx_chain[16];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            first_allow_q   <= 1'b0;
            first_main_q    <= 1'b0;
            first_buf_q     <= 1'b0;
            first_dm_q      <= 1'b0;
            first_idx_q     <= 5'd0;
            exp_word_q      <= 30'd0;
            verdict_valid_q <= 1'b0;
            verdict_allow_q <= 1'b0;
            verdict_main_q  <= 1'b0;
            verdict_buf_q   <= 1'b0;
            verdict_split_q <= 1'b0;
            verdict_dm_q    <= 1'b0;
            verdict_idx_q   <= 5'd0;
            perr_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            first_allow_q   <= first_allow_d;
            first_main_q    <= first_main_d;
            first_buf_q     <= first_buf_d;
            first_dm_q      <= first_dm_d;
            first_idx_q     <= first_idx_d;
            exp_word_q      <= exp_word_d;
            verdict_valid_q <= verdict_valid_d;
            verdict_allow_q <= verdict_allow_d;
            verdict_main_q  <= verdict_main_d;
            verdict_buf_q   <= verdict_buf_d;
            verdict_split_q <= verdict_split_d;
            verdict_dm_q    <= verdict_dm_d;
            verdict_idx_q   <= verdict_idx_d;
            perr_q          <= perr_d;
        end
    end

    // Next state: a legal misaligned beat opens SECOND, any accepted beat closes it
    always_comb begin
        state_d = state_q;
        if (beat_acc) begin
            case (state_q)
                ST_IDLE:   if (!size_bad && beat_mis) state_d = ST_SECOND;
                ST_SECOND: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: verdict pulses, first-half capture and expected second address
    always_comb begin
        verdict_valid_d = 1'b0;
        verdict_allow_d = 1'b0;
        verdict_main_d  = 1'b0;
        verdict_buf_d   = 1'b0;
        verdict_split_d = 1'b0;
        verdict_dm_d    = 1'b0;
        verdict_idx_d   = 5'd0;
        perr_d          = 1'b0;
        first_allow_d   = first_allow_q;
        first_main_d    = first_main_q;
        first_buf_d     = first_buf_q;
        first_dm_d      = first_dm_q;
        first_idx_d     = first_idx_q;
        exp_word_d      = exp_word_q;
        if (beat_acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (size_bad) begin
                        verdict_valid_d = 1'b1;
                        verdict_idx_d   = IDX_NONE;
                        perr_d          = 1'b1;
                    end else if (beat_mis) begin
                        first_allow_d = beat_allow;
                        first_main_d  = beat_main;
                        first_buf_d   = beat_buf;
                        first_dm_d    = beat_dm;
                        first_idx_d   = beat_idx;
                        exp_word_d    = trans_addr_i[31:2] + 30'd1;
                    end else begin
                        verdict_valid_d = 1'b1;
                        verdict_allow_d = beat_allow;
                        verdict_main_d  = beat_main;
                        verdict_buf_d   = beat_buf;
                        verdict_dm_d    = beat_dm;
                        verdict_idx_d   = beat_idx;
                    end
                end
                ST_SECOND: begin
                    verdict_valid_d = 1'b1;
                    verdict_split_d = 1'b1;
                    if (size_bad || (trans_addr_i[31:2] != exp_word_q)) begin
                        verdict_idx_d = IDX_NONE;
                        perr_d        = 1'b1;
                    end else begin
                        verdict_allow_d = first_allow_q & beat_allow;
                        verdict_main_d  = first_main_q & beat_main;
                        verdict_buf_d   = first_buf_q & beat_buf;
                        verdict_dm_d    = first_dm_q | beat_dm;
                        verdict_idx_d   = first_idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating per-region hit counters; clear beats a same-cycle hit
    for (genvar gc = 0; gc < 16; gc++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 cnt_inc;
        assign cnt_inc = beat_acc & ~size_bad & ~beat_dm & rgn_sel[gc];
        always_comb begin
            cnt_d = cnt_q;
            if (clr_cnt_i)                        cnt_d = '0;
            else if (cnt_inc && (cnt_q != '1))    cnt_d = cnt_q + 1'b1;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end
        assign hit_cnt_o[gc*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end

    assign verdict_valid_o      = verdict_valid_q;
    assign verdict_allow_o      = verdict_allow_q;
    assign verdict_main_o       = verdict_main_q;
    assign verdict_bufferable_o = verdict_buf_q;
    assign verdict_split_o      = verdict_split_q;
    assign verdict_dm_o         = verdict_dm_q;
    assign verdict_idx_o        = verdict_idx_q;
    assign protocol_err_o       = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_cv32e40x_pma_split_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_uvmt_cv32e40x_pma_split_model
// Description : Scoreboard bench for the PMA split model. A data-side and an
//               instruction-side instance share one stimulus stream; a
//               transaction-level reference model predicts verdicts and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uvmt_cv32e40x_pma_split_model;
    import uvmt_cv32e40x_pma_split_pkg::*;

    localparam int          NREG   = 4;
    localparam logic [31:0] DM_S   = 32'h1A11_0800;
    localparam logic [31:0] DM_E   = 32'h1A11_0FFF;
    localparam int          W_D    = 3;
    localparam int          W_I    = 2;
    // r0 [0,0x1000) main; r1 [0x2000,0x3000) non-main; r2 [0x800,0x2800) overlaps; r3 top 4 KiB
    localparam pma_cfg_t CFG [NREG-1:0] = '{
        3: '{32'h3FFF_FC00, 32'h4000_0000, 1'b1, 1'b1},
        2: '{32'h0000_0200, 32'h0000_0A00, 1'b0, 1'b1},
        1: '{32'h0000_0800, 32'h0000_0C00, 1'b0, 1'b0},
        0: '{32'h0000_0000, 32'h0000_0400, 1'b1, 1'b1}
    };

    logic        clk, rst_n;
    logic        valid, ready, we, pp, dbg, clr;
    logic [31:0] addr;
    logic [1:0]  size;

    logic        d_valid, d_allow, d_main, d_buf, d_split, d_dm, d_perr;
    logic [4:0]  d_idx;
    logic [16*W_D-1:0] d_cnt;
    logic        i_valid, i_allow, i_main, i_buf, i_split, i_dm, i_perr;
    logic [4:0]  i_idx;
    logic [16*W_I-1:0] i_cnt;

    uvmt_cv32e40x_pma_split_model #(
        .PMA_NUM_REGIONS(NREG), .PMA_CFG(CFG), .DM_REGION_START(DM_S),
        .DM_REGION_END(DM_E), .IS_INSTR_SIDE(1'b0), .CNT_WIDTH(W_D)
    ) u_dut_d (
        .clk(clk), .rst_n(rst_n), .trans_valid_i(valid), .trans_ready_i(ready),
        .trans_addr_i(addr), .trans_size_i(size), .trans_we_i(we),
        .trans_pushpop_i(pp), .dbg_i(dbg), .clr_cnt_i(clr),
        .verdict_valid_o(d_valid), .verdict_allow_o(d_allow), .verdict_main_o(d_main),
        .verdict_bufferable_o(d_buf), .verdict_split_o(d_split), .verdict_dm_o(d_dm),
        .verdict_idx_o(d_idx), .protocol_err_o(d_perr), .hit_cnt_o(d_cnt)
    );

    uvmt_cv32e40x_pma_split_model #(
        .PMA_NUM_REGIONS(NREG), .PMA_CFG(CFG), .DM_REGION_START(DM_S),
        .DM_REGION_END(DM_E), .IS_INSTR_SIDE(1'b1), .CNT_WIDTH(W_I)
    ) u_dut_i (
        .clk(clk), .rst_n(rst_n), .trans_valid_i(valid), .trans_ready_i(ready),
        .trans_addr_i(addr), .trans_size_i(size), .trans_we_i(we),
        .trans_pushpop_i(pp), .dbg_i(dbg), .clr_cnt_i(clr),
        .verdict_valid_o(i_valid), .verdict_allow_o(i_allow), .verdict_main_o(i_main),
        .verdict_bufferable_o(i_buf), .verdict_split_o(i_split), .verdict_dm_o(i_dm),
        .verdict_idx_o(i_idx), .protocol_err_o(i_perr), .hit_cnt_o(i_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit allow, main, bufb, dm, hit, mis;
        int idx;
    } beat_t;
    typedef struct {
        int          due;
        logic [10:0] v;    // {allow, main, buf, split, dm, idx[4:0], perr}
    } exp_t;

    exp_t        q_d[$];
    exp_t        q_i[$];
    int          raw [NREG];
    int          cyc;
    bit          pend;
    logic [31:0] exp_addr;
    beat_t       first [2];
    int          n_chk, n_fail;

    function automatic beat_t eval_beat(logic [31:0] a, logic [1:0] sz, logic w,
                                        logic p, logic d, bit instr);
        beat_t  b;
        longint ua;
        ua     = longint'(a);
        b.hit  = 0; b.idx = 16; b.main = 0; b.bufb = 0;
        b.mis  = ((a % 4) + (1 << sz)) > 4;
        for (int r = NREG - 1; r >= 0; r--)
            if (ua >= longint'(CFG[r].word_addr_low) * 4 && ua < longint'(CFG[r].word_addr_high) * 4) begin
                b.hit = 1;
                b.idx = r;
            end
        b.dm = d && (a >= DM_S) && (a <= DM_E);
        if (b.dm) begin
            b.main = 1; b.allow = 1; b.bufb = 0; b.idx = 16;
        end else begin
            if (b.hit) begin
                b.main = CFG[b.idx].main;
                b.bufb = CFG[b.idx].bufferable && w && !instr;
            end
            b.allow = instr ? b.main : (b.main || (!b.mis && !p));
        end
        return b;
    endfunction

    function automatic logic [10:0] pack(bit al, bit mn, bit bf, bit sp, bit dm, int idx, bit pe);
        return {al, mn, bf, sp, dm, 5'(idx), pe};
    endfunction

    task automatic push_exp(int s, logic [10:0] v);
        exp_t e;
        e.due = cyc;
        e.v   = v;
        if (s == 0) q_d.push_back(e);
        else        q_i.push_back(e);
    endtask

    task automatic model_beat(bit cnt_en);
        beat_t b [2];
        for (int s = 0; s < 2; s++) b[s] = eval_beat(addr, size, we, pp, dbg, s == 1);
        if (size == 2'd3) begin
            for (int s = 0; s < 2; s++) push_exp(s, pack(0, 0, 0, pend, 0, 16, 1));
            pend = 0;
        end else begin
            if (cnt_en && b[0].hit && !b[0].dm) raw[b[0].idx]++;
            if (pend) begin
                for (int s = 0; s < 2; s++)
                    if (addr[31:2] != exp_addr[31:2])
                        push_exp(s, pack(0, 0, 0, 1, 0, 16, 1));
                    else
                        push_exp(s, pack(first[s].allow && b[s].allow, first[s].main && b[s].main,
                                         first[s].bufb && b[s].bufb, 1, first[s].dm || b[s].dm,
                                         first[s].idx, 0));
                pend = 0;
            end else if (b[0].mis) begin
                pend     = 1;
                first    = b;
                exp_addr = (addr & 32'hFFFF_FFFC) + 32'd4;
            end else begin
                for (int s = 0; s < 2; s++)
                    push_exp(s, pack(b[s].allow, b[s].main, b[s].bufb, 0, b[s].dm, b[s].idx, 0));
            end
        end
    endtask

    initial begin
        cyc = 0; pend = 0; exp_addr = '0;
        foreach (raw[r]) raw[r] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend = 0;
                q_d.delete();
                q_i.delete();
                foreach (raw[r]) raw[r] = 0;
            end else begin
                cyc++;
                if (clr) foreach (raw[r]) raw[r] = 0;
                if (valid && ready) model_beat(!clr);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic check_side(int s, logic vld, logic [10:0] act_v);
        exp_t        e;
        bit          have;
        logic [11:0] act, expv;
        have = 0;
        if (s == 0 && q_d.size() > 0 && q_d[0].due <= cyc) begin have = 1; e = q_d.pop_front(); end
        if (s == 1 && q_i.size() > 0 && q_i[0].due <= cyc) begin have = 1; e = q_i.pop_front(); end
        act  = vld ? {1'b1, act_v} : {11'b0, act_v[0]};
        expv = have ? {1'b1, e.v} : 12'b0;
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL verdict side%0d cyc%0d: got {v,al,mn,bf,sp,dm,idx,pe}=%b_%b_%0d_%b expected %b_%b_%0d_%b",
                     s, cyc, act[11], act[10:6], act[5:1], act[0], expv[11], expv[10:6], expv[5:1], expv[0]);
        end
    endtask

    initial begin
        logic [16*W_D-1:0] ecd;
        logic [16*W_I-1:0] eci;
        n_chk = 0; n_fail = 0;
        forever begin
            @(negedge clk);
            check_side(0, d_valid, {d_allow, d_main, d_buf, d_split, d_dm, d_idx, d_perr});
            check_side(1, i_valid, {i_allow, i_main, i_buf, i_split, i_dm, i_idx, i_perr});
            ecd = '0; eci = '0;
            for (int r = 0; r < NREG; r++) begin
                ecd[r*W_D +: W_D] = W_D'((raw[r] > (1 << W_D) - 1) ? (1 << W_D) - 1 : raw[r]);
                eci[r*W_I +: W_I] = W_I'((raw[r] > (1 << W_I) - 1) ? (1 << W_I) - 1 : raw[r]);
            end
            n_chk += 2;
            if (d_cnt !== ecd) begin
                n_fail++;
                $display("FAIL hit_cnt data cyc%0d: got %h expected %h", cyc, d_cnt, ecd);
            end
            if (i_cnt !== eci) begin
                n_fail++;
                $display("FAIL hit_cnt instr cyc%0d: got %h expected %h", cyc, i_cnt, eci);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(logic v, logic r, logic [31:0] a, logic [1:0] sz,
                         logic w, logic p, logic d, logic c);
        valid = v; ready = r; addr = a; size = sz; we = w; pp = p; dbg = d; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic [31:0] a, logic [1:0] sz, logic w, logic p, logic d);
        drive(1, 1, a, sz, w, p, d, 0);
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 2'd0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst_n = 1'b0;
        valid = 0; ready = 0; addr = '0; size = '0; we = 0; pp = 0; dbg = 0; clr = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        beat(32'h0000_0100, 2, 0, 0, 0);  idle();             // aligned main hit
        beat(32'h0000_2002, 2, 0, 0, 0);  beat(32'h0000_2004, 2, 0, 0, 0); idle();
        beat(DM_S, 2, 0, 0, 1);           idle();             // debug window override
        beat(DM_S, 2, 0, 0, 0);           idle();             // same address, not in debug
        beat(32'h0000_0FFE, 2, 0, 0, 0);  beat(32'h0000_1004, 2, 0, 0, 0); idle();
        beat(32'hFFFF_FFFE, 2, 1, 0, 0);  beat(32'h0000_0000, 2, 1, 0, 0); idle();
        drive(1, 0, 32'h0000_0FFF, 1, 0, 0, 0, 0);            // offered, not accepted
        beat(32'h0000_0104, 2, 1, 0, 0);  idle();             // bufferable store
        beat(32'h0000_0100, 3, 0, 0, 0);  idle();             // illegal size
        beat(32'h0000_0901, 0, 0, 0, 0);                       // overlap, r0 wins
        beat(32'h0000_1800, 1, 0, 0, 0);                       // r2 only
        beat(32'h0000_2003, 1, 0, 1, 0);  beat(32'h0000_2004, 0, 0, 1, 0);
        beat(32'h0000_2004, 2, 0, 1, 0);  beat(32'h0000_2008, 2, 0, 0, 0);
        repeat (9) beat(32'h0000_2400, 2, 0, 0, 0);            // saturate r1
        drive(1, 1, 32'h0000_2400, 2, 0, 0, 0, 1);             // clear wins over hit
        beat(32'h0000_2400, 2, 0, 0, 0);  idle();
        beat(32'h0000_2007, 1, 0, 0, 0);  reset_pulse();       // reset between halves
        idle(); idle();
        beat(32'h0000_0100, 2, 0, 0, 0);  idle();
        beat(32'h0000_0FFF, 1, 0, 0, 0);  beat(32'h0000_1000, 3, 0, 0, 0); idle();

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0:       a = $urandom_range(0, 32'h1FFF);
                1:       a = $urandom_range(32'h2000, 32'h2FFF);
                2:       a = $urandom_range(32'h1A11_07F0, 32'h1A11_1010);
                3:       a = 32'hFFFF_F000 + $urandom_range(0, 32'hFFF);
                4:       a = $urandom;
                default: a = $urandom_range(32'h27F0, 32'h2810);
            endcase
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (pend && $urandom_range(0, 3) != 0) begin
                a  = exp_addr;
                sz = 2'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 299) == 0) reset_pulse();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a, sz,
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end
        idle(); idle(); idle();
        n_chk++;
        if (q_d.size() != 0 || q_i.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending verdicts expected 0/0", q_d.size(), q_i.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
